// File: rtl/hsid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hsid_pkg
// Purpose  : Shared types for the hsid pixel scheduler.
// Revision : 1.0
// ============================================================================
package hsid_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_START = 3'd2,
        S_MEAS  = 3'd3,
        S_LIB   = 3'd4,
        S_WAIT  = 3'd5,
        S_RES   = 3'd6
    } hsid_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/hsid_word_counter.sv
`default_nettype none
// ============================================================================
// Module   : hsid_word_counter
// Purpose  : Up-counter that clears on reaching limit-1 and flags the wrap.
// Revision : 1.0
// ============================================================================
module hsid_word_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] r_count;

    // Compare-then-clear: the counter never rolls over modulo 2^WIDTH.
    assign wrap  = inc && (r_count == limit - WIDTH'(1));
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= wrap ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hsid_pixel_sched.sv
`default_nettype none
// ============================================================================
// Module   : hsid_pixel_sched
// Purpose  : Per-pixel batch scheduler feeding hsid_main and collecting results.
// Revision : 1.0
// ============================================================================
module hsid_pixel_sched
    import hsid_pkg::*;
#(
    parameter  int WORD_WIDTH       = 32,
    parameter  int HSI_BANDS        = 255,
    parameter  int HSI_LIBRARY_SIZE = 4095,
    parameter  int MAX_PIXELS       = 1024,
    localparam int HSI_BANDS_ADDR   = $clog2(HSI_BANDS),
    localparam int LIB_ADDR         = $clog2(HSI_LIBRARY_SIZE),
    localparam int PIX_ADDR         = $clog2(MAX_PIXELS) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [PIX_ADDR-1:0]       pixel_count,
    input  logic [LIB_ADDR-1:0]       library_size,
    input  logic [HSI_BANDS_ADDR-1:0] hsi_bands,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_WIDTH-1:0]     in_word,
    output logic                      main_clear,
    output logic                      main_start,
    output logic                      main_vctr_valid,
    output logic [WORD_WIDTH-1:0]     main_vctr,
    output logic [LIB_ADDR-1:0]       main_library_size,
    output logic [HSI_BANDS_ADDR-1:0] main_bands,
    input  logic                      main_ready,
    input  logic                      main_done,
    input  logic [LIB_ADDR-1:0]       main_min_ref,
    input  logic [LIB_ADDR-1:0]       main_max_ref,
    input  logic [WORD_WIDTH-1:0]     main_min_val,
    input  logic [WORD_WIDTH-1:0]     main_max_val,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [PIX_ADDR-2:0]       res_pixel,
    output logic [LIB_ADDR-1:0]       res_min_ref,
    output logic [LIB_ADDR-1:0]       res_max_ref,
    output logic [WORD_WIDTH-1:0]     res_min_val,
    output logic [WORD_WIDTH-1:0]     res_max_val
);

    hsid_sched_state_t r_state;
    hsid_sched_state_t w_next;

    logic [PIX_ADDR-1:0]       r_pix_count;
    logic [PIX_ADDR-1:0]       r_pix;
    logic [LIB_ADDR-1:0]       r_lib_size;
    logic [HSI_BANDS_ADDR-1:0] r_bands;
    logic                      r_kill_clr;

    logic [HSI_BANDS_ADDR-1:0] w_wpv;
    logic                      w_meas;
    logic                      w_lib;
    logic                      w_feed;
    logic                      w_acc;
    logic                      w_proto_err;
    logic                      w_kill;
    logic                      w_cfg_bad;
    logic                      w_launch;
    logic                      w_last;
    logic                      w_res_hs;

    logic [HSI_BANDS_ADDR-1:0] w_wc_count;
    logic                      w_wc_wrap;
    logic [LIB_ADDR-1:0]       w_vc_count;
    logic                      w_vc_wrap;
    logic                      w_unused_counts;

    assign w_wpv       = r_bands >> 1;
    assign w_meas      = (r_state == S_MEAS);
    assign w_lib       = (r_state == S_LIB);
    assign w_feed      = w_meas || w_lib;
    assign w_acc       = w_feed && in_valid && main_ready;
    assign w_proto_err = w_feed && main_done;
    assign w_kill      = (r_state != S_IDLE) && (abort || w_proto_err);
    assign w_cfg_bad   = (pixel_count == '0) || (library_size == '0) ||
                         (hsi_bands[HSI_BANDS_ADDR-1:1] == '0);
    assign w_launch    = (r_state == S_IDLE) && start && !w_cfg_bad;
    assign w_last      = (r_pix == r_pix_count - PIX_ADDR'(1));
    assign w_res_hs    = (r_state == S_RES) && res_ready;

    // Progress is tracked through the wrap flags; raw counts are not consumed here.
    assign w_unused_counts = ^{w_wc_count, w_vc_count};

    hsid_word_counter #(
        .WIDTH (HSI_BANDS_ADDR)
    ) u_wc (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_acc),
        .clr   (w_kill || !w_feed),
        .limit (w_wpv),
        .count (w_wc_count),
        .wrap  (w_wc_wrap)
    );

    hsid_word_counter #(
        .WIDTH (LIB_ADDR)
    ) u_vc (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_lib && w_wc_wrap),
        .clr   (w_kill || !w_lib),
        .limit (r_lib_size),
        .count (w_vc_count),
        .wrap  (w_vc_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_kill) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_launch) w_next = S_CLEAR;
                S_CLEAR: w_next = S_START;
                S_START: w_next = S_MEAS;
                S_MEAS:  if (w_wc_wrap) w_next = S_LIB;
                S_LIB:   if (w_vc_wrap) w_next = S_WAIT;
                S_WAIT:  if (main_done) w_next = S_RES;
                S_RES:   if (res_ready) w_next = w_last ? S_IDLE : S_CLEAR;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy            = (r_state != S_IDLE);
        main_clear      = (r_state == S_CLEAR) || r_kill_clr;
        main_start      = (r_state == S_START);
        in_ready        = w_feed && main_ready;
        main_vctr_valid = w_acc;
        main_vctr       = w_feed ? in_word : '0;
        res_valid       = (r_state == S_RES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done              <= 1'b0;
            err               <= 1'b0;
            r_kill_clr        <= 1'b0;
            r_pix_count       <= '0;
            r_pix             <= '0;
            r_lib_size        <= '0;
            r_bands           <= '0;
            main_library_size <= '0;
            main_bands        <= '0;
            res_pixel         <= '0;
            res_min_ref       <= '0;
            res_max_ref       <= '0;
            res_min_val       <= '0;
            res_max_val       <= '0;
        end else begin
            done       <= 1'b0;
            err        <= ((r_state == S_IDLE) && start && w_cfg_bad) || w_proto_err;
            r_kill_clr <= w_kill;
            if (w_kill) begin
                r_pix <= '0;
            end else begin
                if (w_launch) begin
                    r_pix_count       <= pixel_count;
                    r_lib_size        <= library_size;
                    r_bands           <= hsi_bands;
                    main_library_size <= library_size;
                    main_bands        <= hsi_bands;
                    r_pix             <= '0;
                end
                if ((r_state == S_WAIT) && main_done) begin
                    res_pixel   <= r_pix[PIX_ADDR-2:0];
                    res_min_ref <= main_min_ref;
                    res_max_ref <= main_max_ref;
                    res_min_val <= main_min_val;
                    res_max_val <= main_max_val;
                end
                if (w_res_hs) begin
                    r_pix <= r_pix + PIX_ADDR'(1);
                    done  <= w_last;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hsid_pixel_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hsid_pixel_sched
// Purpose  : Directed scoreboard bench for hsid_pixel_sched.
// Revision : 1.0
// ============================================================================
module tb_hsid_pixel_sched;
    import hsid_pkg::*;

    localparam int WW  = 32;
    localparam int BA  = 8;
    localparam int LA  = 12;
    localparam int PA  = 11;
    localparam int RPW = PA - 1;

    typedef struct packed {
        logic [RPW-1:0] pix;
        logic [LA-1:0]  minr;
        logic [LA-1:0]  maxr;
        logic [WW-1:0]  minv;
        logic [WW-1:0]  maxv;
    } res_t;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [PA-1:0] pixel_count;
    logic [LA-1:0] library_size;
    logic [BA-1:0] hsi_bands;
    logic busy, done, err;
    logic in_valid, in_ready;
    logic [WW-1:0] in_word;
    logic main_clear, main_start, main_vctr_valid;
    logic [WW-1:0] main_vctr;
    logic [LA-1:0] main_library_size;
    logic [BA-1:0] main_bands;
    logic main_ready, main_done;
    logic [LA-1:0] main_min_ref, main_max_ref;
    logic [WW-1:0] main_min_val, main_max_val;
    logic res_valid, res_ready;
    logic [RPW-1:0] res_pixel;
    logic [LA-1:0] res_min_ref, res_max_ref;
    logic [WW-1:0] res_min_val, res_max_val;

    always #5 clk = ~clk;

    hsid_pixel_sched dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .pixel_count       (pixel_count),
        .library_size      (library_size),
        .hsi_bands         (hsi_bands),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_word           (in_word),
        .main_clear        (main_clear),
        .main_start        (main_start),
        .main_vctr_valid   (main_vctr_valid),
        .main_vctr         (main_vctr),
        .main_library_size (main_library_size),
        .main_bands        (main_bands),
        .main_ready        (main_ready),
        .main_done         (main_done),
        .main_min_ref      (main_min_ref),
        .main_max_ref      (main_max_ref),
        .main_min_val      (main_min_val),
        .main_max_val      (main_max_val),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_pixel         (res_pixel),
        .res_min_ref       (res_min_ref),
        .res_max_ref       (res_max_ref),
        .res_min_val       (res_min_val),
        .res_max_val       (res_max_val)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [WW-1:0] exp_q[$];
    res_t res_q[$];
    int cnt_clear, cnt_start, cnt_done, cnt_err, cnt_words, cnt_leak;
    int src_idx = 0;
    int cur_pix = 0;
    bit bp_mode = 1'b0;

    function automatic logic [WW-1:0] wordval(int p, int k);
        return 32'hA500_0000 | WW'(p << 16) | WW'(k);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Sample settled outputs mid-cycle, then advance one clock and drive the source.
    task automatic step();
        #1;
        if (main_clear) cnt_clear++;
        if (main_start) cnt_start++;
        if (done) cnt_done++;
        if (err) cnt_err++;
        if (main_vctr_valid) begin
            cnt_words++;
            if (!main_ready) cnt_leak++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL extra_word: observed %0h, expected none", main_vctr);
            end
            if (exp_q.size() != 0) chk("word", main_vctr, exp_q.pop_front());
        end
        if (in_valid && in_ready) src_idx++;
        @(posedge clk);
        #1;
        main_ready = bp_mode ? ~main_ready : 1'b1;
        in_valid   = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        in_word    = wordval(cur_pix, src_idx);
    endtask

    task automatic feed(input int p, input int nstop, input bit full);
        cur_pix   = p;
        src_idx   = 0;
        in_word   = wordval(p, 0);
        cnt_clear = 0;
        cnt_start = 0;
        cnt_words = 0;
        cnt_leak  = 0;
        for (int k = 0; k < 16; k++) exp_q.push_back(wordval(p, k));
        for (int i = 0; i < 400 && cnt_words < nstop; i++) step();
        if (full) begin
            chk("pix_words", cnt_words, 16);
            chk("no_leak", cnt_leak, 0);
            chk("queue_empty", exp_q.size(), 0);
            chk("clear_once", cnt_clear, 1);
            chk("start_once", cnt_start, 1);
        end
    endtask

    task automatic finish_pixel(input int p, input bit stall, input bit last);
        res_t e;
        int   st0;
        repeat (2) step();
        chk("wait_in_ready", in_ready, 0);
        chk("wait_busy", busy, 1);
        chk("main_bands", main_bands, hsi_bands);
        chk("main_libsize", main_library_size, library_size);
        main_min_ref = LA'(p + 1);
        main_max_ref = LA'(p + 2);
        main_min_val = $urandom;
        main_max_val = $urandom;
        res_q.push_back('{pix: RPW'(p), minr: main_min_ref, maxr: main_max_ref,
                          minv: main_min_val, maxv: main_max_val});
        main_done = 1'b1;
        step();
        main_done = 1'b0;
        for (int i = 0; i < 20 && !res_valid; i++) step();
        chk("res_valid", res_valid, 1);
        e = res_q[0];
        if (stall) begin
            st0 = cnt_start;
            for (int i = 0; i < 10; i++) begin
                step();
                chk("stall_pixel", res_pixel, e.pix);
                chk("stall_minv", res_min_val, e.minv);
            end
            chk("stall_valid", res_valid, 1);
            chk("stall_no_start", cnt_start - st0, 0);
        end
        chk("res_pixel", res_pixel, e.pix);
        chk("res_min_ref", res_min_ref, e.minr);
        chk("res_max_ref", res_max_ref, e.maxr);
        chk("res_min_val", res_min_val, e.minv);
        chk("res_max_val", res_max_val, e.maxv);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        void'(res_q.pop_front());
        chk("res_drop", res_valid, 0);
        chk("done_pulse", done, last);
        chk("busy_after", busy, !last);
    endtask

    task automatic launch(input int pc, input int ls, input int hb);
        pixel_count  = PA'(pc);
        library_size = LA'(ls);
        hsi_bands    = BA'(hb);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pixel_count = '0; library_size = '0; hsi_bands = '0;
        in_valid = 1'b0; in_word = '0; main_ready = 1'b1; main_done = 1'b0;
        main_min_ref = '0; main_max_ref = '0; main_min_val = '0; main_max_val = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_clear", main_clear, 0);
        chk("rst_res_valid", res_valid, 0);
        rst = 1'b0;
        step();

        // Nominal two-pixel batch
        cnt_done = 0; cnt_err = 0;
        launch(2, 3, 8);
        chk("busy_on_start", busy, 1);
        feed(0, 16, 1);
        finish_pixel(0, 0, 0);
        feed(1, 16, 1);
        finish_pixel(1, 0, 1);
        repeat (3) step();
        chk("nom_done_count", cnt_done, 1);
        chk("nom_err_count", cnt_err, 0);

        // Backpressure and result stall
        bp_mode = 1'b1;
        launch(2, 3, 8);
        feed(0, 16, 1);
        finish_pixel(0, 1, 0);
        feed(1, 16, 1);
        finish_pixel(1, 0, 1);
        bp_mode = 1'b0;
        repeat (2) step();

        // Bad configuration
        cnt_clear = 0; cnt_start = 0; cnt_err = 0;
        launch(1, 0, 8);
        chk("bad_err", err, 1);
        chk("bad_busy", busy, 0);
        repeat (2) step();
        chk("bad_err_pulse", cnt_err, 1);
        chk("bad_err_low", err, 0);
        chk("bad_no_clear", cnt_clear, 0);
        chk("bad_no_start", cnt_start, 0);
        chk("bad_busy_later", busy, 0);

        // Abort during measure phase of pixel 1
        launch(2, 3, 8);
        feed(0, 16, 1);
        finish_pixel(0, 0, 0);
        feed(1, 2, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        chk("abort_clear", main_clear, 1);
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        cnt_done = 0;
        step();
        chk("abort_clear_1cyc", main_clear, 0);
        repeat (4) step();
        chk("abort_no_done", cnt_done, 0);
        launch(1, 3, 8);
        feed(0, 16, 1);
        finish_pixel(0, 0, 1);
        repeat (2) step();

        // Reset in the middle of the library phase
        launch(1, 3, 8);
        feed(0, 6, 0);
        rst = 1'b1;
        repeat (3) step();
        exp_q.delete();
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_err", err, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_clear", main_clear, 0);
        chk("mrst_start", main_start, 0);
        chk("mrst_vvalid", main_vctr_valid, 0);
        chk("mrst_vctr", main_vctr, 0);
        chk("mrst_libsize", main_library_size, 0);
        chk("mrst_bands", main_bands, 0);
        chk("mrst_res_valid", res_valid, 0);
        chk("mrst_res_pixel", res_pixel, 0);
        chk("mrst_res_minr", res_min_ref, 0);
        chk("mrst_res_maxr", res_max_ref, 0);
        chk("mrst_res_minv", res_min_val, 0);
        chk("mrst_res_maxv", res_max_val, 0);
        rst = 1'b0;
        step();
        chk("mrst_idle_busy", busy, 0);
        chk("mrst_idle_in_ready", in_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
